// File: rtl/max_pkg.sv
// Shared types for the frame extreme-value search block.
// Holds the FSM encoding and the ceil-log2 helper.
package max_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/max_cmp.sv
// Replacement decision: SEL_A is set when A is strictly
// better than B (greater for MODE=0, smaller for MODE=1).
module max_cmp #(
  parameter int WIDTH  = 12,
  parameter int SIGNED = 0
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             MODE,
  output logic             SEL_A
);

  logic gt;
  logic lt;

  generate
    if (SIGNED != 0) begin : g_s
      assign gt = $signed(A) > $signed(B);
      assign lt = $signed(A) < $signed(B);
    end else begin : g_u
      assign gt = A > B;
      assign lt = A < B;
    end
  endgenerate

  assign SEL_A = MODE ? lt : gt;

endmodule

// File: rtl/max_frame_search.sv
// Streams samples of a frame and reports the extreme value,
// its first position and the frame length.
module max_frame_search
  import max_pkg::*;
#(
  parameter int WIDTH     = 12,
  parameter int FRAME_LEN = 64,
  parameter int SIGNED    = 0,
  localparam int IDX_W    = clog2(FRAME_LEN)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             MODE,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] IN_DATA,
  input  logic             IN_LAST,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] OUT_DATA,
  output logic [IDX_W-1:0] OUT_INDEX,
  output logic [IDX_W:0]   OUT_COUNT
);

  localparam logic [IDX_W:0] FULL = (IDX_W+1)'(FRAME_LEN);
  localparam logic [IDX_W:0] ONE  = (IDX_W+1)'(1);

  state_t           state;
  state_t           state_n;
  logic [WIDTH-1:0] best_q;
  logic [WIDTH-1:0] best_n;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_n;
  logic [IDX_W:0]   cnt_q;
  logic [IDX_W:0]   cnt_n;
  logic             mode_q;
  logic             mode_n;
  logic             rdy_q;
  logic             take;
  logic             close;
  logic             sel;

  assign take     = IN_VALID & rdy_q;
  assign IN_READY = rdy_q;

  max_cmp #(
    .WIDTH (WIDTH),
    .SIGNED(SIGNED)
  ) u_cmp (
    .A    (IN_DATA),
    .B    (best_q),
    .MODE (mode_q),
    .SEL_A(sel)
  );

  always_comb begin
    state_n = state;
    best_n  = best_q;
    idx_n   = idx_q;
    cnt_n   = cnt_q;
    mode_n  = mode_q;
    close   = 1'b0;
    unique case (state)
      IDLE: begin
        if (take) begin
          best_n  = IN_DATA;
          idx_n   = '0;
          cnt_n   = ONE;
          mode_n  = MODE;
          state_n = ACC;
          close   = IN_LAST;
        end
      end
      ACC: begin
        if (take) begin
          cnt_n = cnt_q + ONE;
          if (sel) begin
            best_n = IN_DATA;
            idx_n  = cnt_q[IDX_W-1:0];
          end
          close = IN_LAST | (cnt_n == FULL);
        end
      end
      HOLD: begin
        if (OUT_READY) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (close) state_n = HOLD;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      best_q    <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      mode_q    <= 1'b0;
      rdy_q     <= 1'b0;
      OUT_VALID <= 1'b0;
      OUT_DATA  <= '0;
      OUT_INDEX <= '0;
      OUT_COUNT <= '0;
    end else begin
      state  <= state_n;
      best_q <= best_n;
      idx_q  <= idx_n;
      cnt_q  <= cnt_n;
      mode_q <= mode_n;
      // Ready is registered so it drops in the same cycle HOLD begins
      rdy_q  <= (state_n != HOLD);
      if (close) begin
        OUT_VALID <= 1'b1;
        OUT_DATA  <= best_n;
        OUT_INDEX <= idx_n;
        OUT_COUNT <= cnt_n;
      end else if (state == HOLD && OUT_READY) begin
        OUT_VALID <= 1'b0;
      end
    end
  end

endmodule

// File: doc/max_frame_search.md
MAX_FRAME_SEARCH -- requirements
Module: max_frame_search

Interface
REQ-001 SHALL have parameter WIDTH, default 12: sample width in bits.
REQ-002 SHALL have parameter FRAME_LEN, default 64: maximum samples per frame, legal range 2..4096.
REQ-003 SHALL have parameter SIGNED, default 0: 0 means unsigned compare, 1 means two's-complement compare.
REQ-004 SHALL derive IDX_W = clog2(FRAME_LEN) as a local constant.
REQ-005 SHALL have port CLK  input  1  single system clock, rising edge.
REQ-006 SHALL have port RST  input  1  reset, asynchronous and active-high.
REQ-007 SHALL have port MODE  input  1  0 selects maximum search, 1 selects minimum search.
REQ-008 SHALL have port IN_VALID  input  1  sample present.
REQ-009 SHALL have port IN_READY  output  1  block accepts a sample.
REQ-010 SHALL have port IN_DATA  input  WIDTH  sample value.
REQ-011 SHALL have port IN_LAST  input  1  marks the final sample of a short frame.
REQ-012 SHALL have port OUT_VALID  output  1  result present.
REQ-013 SHALL have port OUT_READY  input  1  consumer accepts the result.
REQ-014 SHALL have port OUT_DATA  output  WIDTH  extreme value of the frame.
REQ-015 SHALL have port OUT_INDEX  output  IDX_W  zero-based position of that value.
REQ-016 SHALL have port OUT_COUNT  output  IDX_W+1  number of samples in the frame.

Function
REQ-017 SHALL accept a sample on any rising CLK edge where IN_VALID and IN_READY are both 1.
REQ-018 SHALL implement three states: IDLE (no frame open), ACC (frame open) and HOLD (result pending).
REQ-019 SHALL drive IN_READY = 1 in IDLE and ACC, and IN_READY = 0 in HOLD.
REQ-020 SHALL, on accepting a sample in IDLE, load that sample as the best value, set best index to 0, set count to 1, latch MODE and enter ACC.
REQ-021 SHALL ignore MODE at all times other than the frame's first accepted sample.
REQ-022 SHALL, on accepting a sample in ACC, replace the best value and index only when the sample is strictly greater (MODE=0) or strictly less (MODE=1); on ties the first occurrence is kept.
REQ-023 SHALL compare using the signedness given by SIGNED.
REQ-024 SHALL close the frame on the accepted sample that has IN_LAST=1 or that brings the count to FRAME_LEN, whichever occurs first; that sample is included in the result.
REQ-025 SHALL close a frame on its first sample when that sample has IN_LAST=1, giving a one-sample frame with index 0 and count 1.
REQ-026 SHALL, on frame close, enter HOLD and assert OUT_VALID from the next cycle, giving one cycle of latency from the last accepted sample.
REQ-027 SHALL hold OUT_VALID, OUT_DATA, OUT_INDEX and OUT_COUNT stable in HOLD until a cycle with OUT_READY = 1, then return to IDLE with OUT_VALID = 0 on the following cycle.
REQ-028 SHALL NOT assert IN_READY in the cycle in which the result is taken; a new frame may start on the cycle after.
REQ-029 SHALL leave OUT_DATA, OUT_INDEX and OUT_COUNT undefined-free (holding their last values) while OUT_VALID = 0.
REQ-030 SHALL NOT wrap the count: the count never exceeds FRAME_LEN.
REQ-031 SHALL ignore IN_DATA and IN_LAST when IN_VALID = 0.

Reset
REQ-032 SHALL, on RST asserted, immediately place the block in IDLE and clear OUT_VALID, OUT_DATA, OUT_INDEX, OUT_COUNT, the count and the latched mode to 0, independent of CLK.
REQ-033 SHALL discard any partially accumulated frame, or any pending result, when RST is asserted mid-operation, with no output produced for it.
REQ-034 SHALL drive IN_READY = 0 while RST = 1, and drive it to 1 on the first CLK edge after release.

Structure
REQ-035 SHALL place the state encodings (IDLE, ACC, HOLD) and the clog2 helper in the shared package max_pkg.
REQ-036 SHALL instantiate one combinational sub-module, max_cmp (parameters WIDTH and SIGNED; inputs A, B and MODE; output SEL_A), which decides whether the new sample replaces the best value.
REQ-037 SHALL register all outputs, with no combinational path from IN_* to OUT_*.

Verification (WIDTH=12, FRAME_LEN=4)
REQ-038 SHALL verify a full unsigned max frame: SIGNED=0, MODE=0, samples 5, 0xFFF, 7, 0xFFF -> OUT_DATA=0xFFF, OUT_INDEX=1, OUT_COUNT=4, with OUT_VALID one cycle after the 4th sample.
REQ-039 SHALL verify a signed min frame: SIGNED=1, MODE=1, samples 0x001, 0x800, 0x7FF -> OUT_DATA=0x800, OUT_INDEX=1, OUT_COUNT=3.
REQ-040 SHALL verify early termination: samples 9, 3 with IN_LAST on 3 -> OUT_DATA=9, OUT_INDEX=0, OUT_COUNT=2; and a single sample 0x123 with IN_LAST -> OUT_DATA=0x123, OUT_INDEX=0, OUT_COUNT=1.
REQ-041 SHALL verify backpressure: hold OUT_READY=0 for 10 cycles -> OUT_* stable, IN_READY=0, samples offered meanwhile are not taken; raise OUT_READY -> IDLE, and the next frame is correct.
REQ-042 SHALL verify reset mid-frame: assert RST after 2 of 4 samples -> OUT_VALID=0 immediately; a new frame 1, 2, 3, 4 yields OUT_DATA=4, OUT_INDEX=3, OUT_COUNT=4 with nothing carried over.
REQ-043 SHALL verify a MODE change mid-frame: MODE=0 at the first sample, MODE=1 thereafter, samples 2, 8, 1, 3 -> OUT_DATA=8, OUT_INDEX=1.
